// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch/decode/update sequencer that drives the pc block's
//            increment and relative-branch controls.
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
  parameter int Psize   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             imem_ready,
  input  logic             is_branch,
  input  logic             flag,
  input  logic             is_halt,
  input  logic [Psize-1:0] offset,
  input  logic             stall,
  output logic             fetch_req,
  output logic             ir_load,
  output logic             PCincr,
  output logic             PCrelbranch,
  output logic [Psize-1:0] Branchaddr,
  output logic             halted,
  output logic             fault,
  output logic [7:0]       instr_count
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WCW-1:0]   wait_cnt;
  logic             take;
  logic [Psize-1:0] off;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      take        <= 1'b0;
      off         <= '0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      // Counter only runs while waiting in FETCH, so it is zero on every entry.
      if (state == S_FETCH && !imem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (state == S_DECODE && !is_halt) begin
        take <= is_branch & flag;
        off  <= offset;
      end
      if (state == S_UPDATE && !stall && instr_count != 8'hFF)
        instr_count <= instr_count + 8'd1;
    end
  end

  always_comb begin
    next_state  = state;
    fetch_req   = 1'b0;
    ir_load     = 1'b0;
    PCincr      = 1'b0;
    PCrelbranch = 1'b0;
    Branchaddr  = '0;
    halted      = 1'b0;
    fault       = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) next_state = S_FETCH;
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          next_state = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_FAULT;
        end
      end
      S_DECODE: begin
        next_state = is_halt ? S_HALT : S_UPDATE;
      end
      S_UPDATE: begin
        if (!stall) begin
          PCincr      = ~take;
          PCrelbranch = take;
          Branchaddr  = take ? off : '0;
          next_state  = run ? S_FETCH : S_IDLE;
        end
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed vector bench for pc_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       imem_ready;
  logic       is_branch;
  logic       flag;
  logic       is_halt;
  logic [3:0] offset;
  logic       stall;
  logic       fetch_req;
  logic       ir_load;
  logic       PCincr;
  logic       PCrelbranch;
  logic [3:0] Branchaddr;
  logic       halted;
  logic       fault;
  logic [7:0] instr_count;

  int applied = 0;
  int miscompares = 0;

  pc_sequencer #(.Psize(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_ready(imem_ready),
    .is_branch(is_branch), .flag(flag), .is_halt(is_halt), .offset(offset),
    .stall(stall), .fetch_req(fetch_req), .ir_load(ir_load), .PCincr(PCincr),
    .PCrelbranch(PCrelbranch), .Branchaddr(Branchaddr), .halted(halted),
    .fault(fault), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, run, rdy, br, fl, hlt;
    logic [3:0] off;
    logic       stl;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Expected bundle layout: {fetch_req, ir_load, PCincr, PCrelbranch,
  // Branchaddr[3:0], halted, fault, instr_count[7:0]}.
  function automatic vec_t v(input logic rst_n, run_i, rdy, br, fl, hlt,
                             input logic [3:0] off, input logic stl,
                             input logic fr, il, inc, rel,
                             input logic [3:0] ba, input logic hd, ft,
                             input logic [7:0] cnt);
    vec_t r;
    r.rst_n = rst_n; r.run = run_i; r.rdy = rdy; r.br = br; r.fl = fl;
    r.hlt = hlt; r.off = off; r.stl = stl;
    r.exp = {fr, il, inc, rel, ba, hd, ft, cnt};
    return r;
  endfunction

  function automatic logic [17:0] outs();
    return {fetch_req, ir_load, PCincr, PCrelbranch, Branchaddr, halted, fault, instr_count};
  endfunction

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %05h expected %05h (fr,il,inc,rel,ba,hd,ft,cnt)", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    reset = x.rst_n; run = x.run; imem_ready = x.rdy; is_branch = x.br;
    flag = x.fl; is_halt = x.hlt; offset = x.off; stall = x.stl;
  endtask

  task automatic fetch_pair(input logic [7:0] c);
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 1,1,0,0,4'h0,0,0,c));
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; imem_ready = 1'b0; is_branch = 1'b0;
    flag = 1'b0; is_halt = 1'b0; offset = 4'h0; stall = 1'b0;

    // Reset, idle, then three plain instructions back to back.
    vecs.push_back(v(0,0,0,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd0));
    vecs.push_back(v(1,0,0,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd0));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd0));
    for (int i = 0; i < 3; i++) begin
      fetch_pair(8'(i));
      vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'(i)));
      vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,1,0,4'h0,0,0,8'(i)));
    end
    // Taken branch; UPDATE inputs changed to prove off/take were latched.
    fetch_pair(8'd3);
    vecs.push_back(v(1,1,1,1,1,0,4'hF,0, 0,0,0,0,4'h0,0,0,8'd3));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,1,4'hF,0,0,8'd3));
    // Not-taken branch.
    fetch_pair(8'd4);
    vecs.push_back(v(1,1,1,1,0,0,4'hF,0, 0,0,0,0,4'h0,0,0,8'd4));
    vecs.push_back(v(1,1,1,1,1,0,4'h3,0, 0,0,1,0,4'h0,0,0,8'd4));
    // Four stalled UPDATE cycles, then one increment.
    fetch_pair(8'd5);
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd5));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(1,1,1,0,0,0,4'h0,1, 0,0,0,0,4'h0,0,0,8'd5));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,1,0,4'h0,0,0,8'd5));
    // run drops mid-instruction: instruction completes, then IDLE.
    vecs.push_back(v(1,0,0,0,0,0,4'h0,0, 1,0,0,0,4'h0,0,0,8'd6));
    vecs.push_back(v(1,0,1,0,0,0,4'h0,0, 1,1,0,0,4'h0,0,0,8'd6));
    vecs.push_back(v(1,0,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd6));
    vecs.push_back(v(1,0,1,0,0,0,4'h0,0, 0,0,1,0,4'h0,0,0,8'd6));
    vecs.push_back(v(1,0,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd7));
    vecs.push_back(v(1,1,0,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd7));
    // Seven wait cycles then ready: no fault.
    for (int i = 0; i < 7; i++)
      vecs.push_back(v(1,1,0,0,0,0,4'h0,0, 1,0,0,0,4'h0,0,0,8'd7));
    fetch_pair(8'd7);
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd7));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,1,0,4'h0,0,0,8'd7));
    // Eight wait cycles: fault from the ninth, sticky.
    for (int i = 0; i < 8; i++)
      vecs.push_back(v(1,1,0,0,0,0,4'h0,0, 1,0,0,0,4'h0,0,0,8'd8));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,1,8'd8));
    vecs.push_back(v(1,0,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,1,8'd8));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,1,8'd8));
    // Reset clears fault; halt beats branch and ignores run.
    vecs.push_back(v(0,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd0));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd0));
    fetch_pair(8'd0);
    vecs.push_back(v(1,1,1,1,1,1,4'h5,0, 0,0,0,0,4'h0,0,0,8'd0));
    vecs.push_back(v(1,0,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,1,0,8'd0));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,1,0,8'd0));
    vecs.push_back(v(1,0,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,1,0,8'd0));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,1,0,8'd0));
    // Leave halt by reset and run up to the DECODE of a second instruction.
    vecs.push_back(v(0,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd0));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd0));
    fetch_pair(8'd0);
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd0));
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,1,0,4'h0,0,0,8'd0));
    fetch_pair(8'd1);
    vecs.push_back(v(1,1,1,0,0,0,4'h0,0, 0,0,0,0,4'h0,0,0,8'd1));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #2;
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of an incrementing UPDATE.
    chk("upd_before_reset", outs(), {4'b0010, 4'h0, 2'b00, 8'd1});
    #2 reset = 1'b0;
    #1 chk("async_reset", outs(), 18'h0);
    @(posedge clk); #1;
    chk("reset_held", outs(), 18'h0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_to_fetch", outs(), {4'b1100, 4'h0, 2'b00, 8'd0});

    // Counter saturation at 255.
    repeat (3 * 254) @(posedge clk);
    #1 chk("count_254", outs(), {4'b1100, 4'h0, 2'b00, 8'd254});
    repeat (3 * 6) @(posedge clk);
    #1 chk("count_sat", outs(), {4'b1100, 4'h0, 2'b00, 8'd255});

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
